// File: rtl/seq_machine_n.sv
// seq_machine_n: N-bit Moore state machine stepping in hold/binary/Gray/shift modes, with target decode, wrap pulse and saturating target-entry count.
//   CLK      in   rising-edge clock
//   RESET    in   synchronous active-high reset
//   x        in   count direction (1 = up) or serial data in shift mode
//   mode     in   00 hold, 01 binary count, 10 Gray count, 11 shift
//   clr_hits in   synchronous clear of HITS, wins over a same-edge entry
//   F        out  S == TARGET
//   S        out  state register
//   WRAP     out  one-cycle pulse after a count crosses all-ones <-> 0
//   HITS     out  saturating count of entries into TARGET
module seq_machine_n #(
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] TARGET = WIDTH'(3'b110),
  parameter logic [WIDTH-1:0] RESET_STATE = '0,
  parameter int HIT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             x,
  input  logic [1:0]       mode,
  input  logic             clr_hits,
  output logic             F,
  output logic [WIDTH-1:0] S,
  output logic             WRAP,
  output logic [HIT_W-1:0] HITS
);
  typedef enum logic [1:0] {HOLD = 2'b00, BIN = 2'b01, GRAY = 2'b10, SHIFT = 2'b11} mode_e;
  mode_e m;
  logic [WIDTH-1:0] g2b, bv, bn, sn;
  logic wrap_n;
  logic [HIT_W-1:0] hits_n;
  assign m = mode_e'(mode);
  assign F = S == TARGET;
  always_comb begin
    g2b = S;
    for (int i = WIDTH - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ S[i];
    bv = m == GRAY ? g2b : S;
    bn = x ? bv + WIDTH'(1) : bv - WIDTH'(1);
    sn = m == HOLD ? S : m == BIN ? bn : m == GRAY ? bn ^ (bn >> 1) : {S[WIDTH-2:0], x};
    wrap_n = (m == BIN || m == GRAY) && (x ? &bv : ~|bv);
    hits_n = clr_hits ? '0 : (sn == TARGET && S != TARGET && !(&HITS)) ? HITS + HIT_W'(1) : HITS;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      S <= RESET_STATE;
      WRAP <= 1'b0;
      HITS <= '0;
    end else begin
      S <= sn;
      WRAP <= wrap_n;
      HITS <= hits_n;
    end
  end
endmodule

// File: tb/tb_seq_machine_n.sv
// tb_seq_machine_n: directed vector bench for seq_machine_n across three parameter sets.
module tb_seq_machine_n;
  logic clk = 1'b0, rst, x, clr;
  logic [1:0] mode;
  logic f0, f1, f2, w0, w1, w2;
  logic [2:0] s0, s1, s2;
  logic [3:0] h0, h2;
  logic [1:0] h1;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  seq_machine_n u0 (.CLK(clk), .RESET(rst), .x(x), .mode(mode), .clr_hits(clr),
                    .F(f0), .S(s0), .WRAP(w0), .HITS(h0));
  seq_machine_n #(.HIT_W(2)) u1 (.CLK(clk), .RESET(rst), .x(x), .mode(mode), .clr_hits(clr),
                    .F(f1), .S(s1), .WRAP(w1), .HITS(h1));
  seq_machine_n #(.RESET_STATE(3'b110)) u2 (.CLK(clk), .RESET(rst), .x(x), .mode(mode), .clr_hits(clr),
                    .F(f2), .S(s2), .WRAP(w2), .HITS(h2));

  typedef struct {
    int sel;
    logic rst;
    logic [1:0] mode;
    logic x, clr;
    logic [2:0] s;
    logic f, w;
    logic [3:0] h;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic r, input logic [1:0] md, input logic xi, input logic c,
                     input logic [2:0] s, input logic f, input logic w, input logic [3:0] h);
    v.push_back('{sel, r, md, xi, c, s, f, w, h});
  endtask

  task automatic step(input logic r, input logic [1:0] md, input logic xi, input logic c);
    rst = r; mode = md; x = xi; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; x = 1'b0; clr = 1'b0;
    add(0, 1, 2'($urandom), 1'($urandom), 0, 3'b000, 0, 0, 0);
    add(0, 1, 2'($urandom), 1'($urandom), 1, 3'b000, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b001, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b010, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b011, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b100, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b101, 0, 0, 0);
    add(0, 0, 2'b01, 1, 0, 3'b110, 1, 0, 1);
    add(0, 0, 2'b01, 1, 0, 3'b111, 0, 0, 1);
    add(0, 0, 2'b01, 1, 0, 3'b000, 0, 1, 1);
    add(0, 0, 2'b01, 0, 0, 3'b111, 0, 1, 1);
    add(0, 0, 2'b00, 0, 0, 3'b111, 0, 0, 1);
    add(0, 0, 2'b00, 1, 0, 3'b111, 0, 0, 1);
    add(0, 0, 2'b00, 0, 0, 3'b111, 0, 0, 1);
    add(0, 0, 2'b11, 1, 0, 3'b111, 0, 0, 1);
    add(0, 1, 2'b10, 1, 0, 3'b000, 0, 0, 0);
    add(0, 0, 2'b10, 1, 0, 3'b001, 0, 0, 0);
    add(0, 0, 2'b10, 1, 0, 3'b011, 0, 0, 0);
    add(0, 0, 2'b10, 1, 0, 3'b010, 0, 0, 0);
    add(0, 0, 2'b10, 1, 0, 3'b110, 1, 0, 1);
    add(0, 0, 2'b10, 1, 0, 3'b111, 0, 0, 1);
    add(0, 0, 2'b10, 1, 0, 3'b101, 0, 0, 1);
    add(0, 0, 2'b10, 1, 0, 3'b100, 0, 0, 1);
    add(0, 0, 2'b10, 1, 0, 3'b000, 0, 1, 1);
    add(0, 0, 2'b10, 0, 0, 3'b100, 0, 1, 1);
    add(0, 0, 2'b01, 1, 0, 3'b101, 0, 0, 1);
    add(0, 1, 2'b01, 1, 0, 3'b000, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(1, 0, 2'b11, 1, 0, 3'b001, 0, 0, 4'(k));
      add(1, 0, 2'b11, 1, 0, 3'b011, 0, 0, 4'(k));
      add(1, 0, 2'b11, 0, 0, 3'b110, 1, 0, k < 3 ? 4'(k + 1) : 4'd3);
      add(1, 0, 2'b11, 0, 0, 3'b100, 0, 0, k < 3 ? 4'(k + 1) : 4'd3);
    end
    add(1, 0, 2'b11, 1, 0, 3'b001, 0, 0, 3);
    add(1, 0, 2'b11, 1, 0, 3'b011, 0, 0, 3);
    add(1, 0, 2'b11, 0, 1, 3'b110, 1, 0, 0);
    add(1, 0, 2'b00, 0, 0, 3'b110, 1, 0, 0);
    add(1, 0, 2'b00, 1, 0, 3'b110, 1, 0, 0);

    foreach (v[i]) begin
      step(v[i].rst, v[i].mode, v[i].x, v[i].clr);
      case (v[i].sel)
        0: begin
          chk("S", i, s0, v[i].s); chk("F", i, f0, v[i].f);
          chk("WRAP", i, w0, v[i].w); chk("HITS", i, h0, v[i].h);
        end
        default: begin
          chk("S", i, s1, v[i].s); chk("F", i, f1, v[i].f);
          chk("WRAP", i, w1, v[i].w); chk("HITS", i, h1, v[i].h);
        end
      endcase
    end

    step(1, 2'b01, 1, 0);
    chk("rst_into_target S", 0, s2, 3'b110);
    chk("rst_into_target F", 0, f2, 1);
    chk("rst_into_target HITS", 0, h2, 0);
    step(0, 2'b01, 0, 0);
    chk("down_from_target S", 1, s2, 3'b101);
    chk("down_from_target F", 1, f2, 0);
    step(0, 2'b01, 1, 0);
    chk("reentry S", 2, s2, 3'b110);
    chk("reentry HITS", 2, h2, 1);
    step(0, 2'b01, 0, 0);
    chk("leave S", 3, s2, 3'b101);
    step(1, 2'b01, 1, 0);
    chk("mid_rst S", 4, s2, 3'b110);
    chk("mid_rst F", 4, f2, 1);
    chk("mid_rst WRAP", 4, w2, 0);
    chk("mid_rst HITS", 4, h2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
